// File: rtl/project_info_pkg.sv
// Shared types and sizing helpers for the build-identification frame streamer.
package project_info_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHdr  = 2'd1,
        StPay  = 2'd2,
        StCsum = 2'd3
    } state_e;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;
    localparam int unsigned DEFAULT_DEPTH = 8;
    localparam int unsigned DEFAULT_COMMIT_HASH_DEPTH = 32;

    function automatic int unsigned payload_bytes(input int unsigned depth,
                                                  input int unsigned hash_depth);
        return (4 * depth) / 8 + hash_depth / 8;
    endfunction

endpackage

// File: rtl/project_info_streamer.sv
// Streams HEADER, the four version fields, the commit hash and an XOR checksum as a
// valid/ready byte frame; all fields are snapshotted when the request is accepted.
module project_info_streamer
    import project_info_pkg::*;
#(
    parameter int unsigned DEPTH             = DEFAULT_DEPTH,
    parameter int unsigned COMMIT_HASH_DEPTH = DEFAULT_COMMIT_HASH_DEPTH,
    parameter logic [7:0]  HEADER            = DEFAULT_HEADER
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_req,
    input  logic [DEPTH-1:0]             i_major,
    input  logic [DEPTH-1:0]             i_minor,
    input  logic [DEPTH-1:0]             i_patch,
    input  logic [DEPTH-1:0]             i_build,
    input  logic [COMMIT_HASH_DEPTH-1:0] i_commit_hash,
    output logic [7:0]                   o_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic                         o_last,
    output logic                         o_busy,
    output logic                         o_done
);

    localparam int unsigned PayloadBytes = payload_bytes(DEPTH, COMMIT_HASH_DEPTH);
    localparam int unsigned ShiftW       = 8 * PayloadBytes;
    localparam int unsigned CntW         = $clog2(PayloadBytes + 1);

    if ((DEPTH % 8) != 0 || DEPTH < 8 ||
        (COMMIT_HASH_DEPTH % 8) != 0 || COMMIT_HASH_DEPTH < 8) begin : g_width_check
        $error("DEPTH and COMMIT_HASH_DEPTH must be non-zero multiples of 8");
    end

    state_e            state_q, state_d;
    logic [ShiftW-1:0] shift_q, shift_d;
    logic [7:0]        csum_q,  csum_d;
    logic [CntW-1:0]   cnt_q,   cnt_d;
    logic [7:0]        data_q,  data_d;
    logic              valid_q, valid_d;
    logic              last_q,  last_d;
    logic              done_q,  done_d;
    logic              xfer;

    assign xfer = valid_q && i_ready;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        csum_d  = csum_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_req) begin
                    shift_d = {i_major, i_minor, i_patch, i_build, i_commit_hash};
                    csum_d  = 8'h00;
                    cnt_d   = CntW'(PayloadBytes);
                    data_d  = HEADER;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    state_d = StHdr;
                end
            end
            StHdr: begin
                if (xfer) begin
                    data_d  = shift_q[ShiftW-1 -: 8];
                    state_d = StPay;
                end
            end
            StPay: begin
                // data_q always mirrors the top byte of shift_q while in this state.
                if (xfer) begin
                    shift_d = shift_q << 8;
                    csum_d  = csum_q ^ data_q;
                    cnt_d   = cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        data_d  = csum_q ^ data_q;
                        last_d  = 1'b1;
                        state_d = StCsum;
                    end else begin
                        data_d = shift_q[ShiftW-9 -: 8];
                    end
                end
            end
            StCsum: begin
                if (xfer) begin
                    data_d  = 8'h00;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            shift_q <= '0;
            csum_q  <= 8'h00;
            cnt_q   <= '0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            csum_q  <= csum_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_last  = last_q;
    assign o_done  = done_q;
    assign o_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_project_info_streamer.sv
// Bench for project_info_streamer: table vectors, random fields/backpressure against a
// frame model, plus mid-frame reset and a 16/8-bit width variant.
module tb_project_info_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, ready;
    logic [7:0]  major, minor, patch, build;
    logic [31:0] hash;
    logic [7:0]  data;
    logic        valid, last, busy, done;

    logic        req_b;
    logic [15:0] major_b, minor_b, patch_b, build_b;
    logic [7:0]  hash_b;
    logic [7:0]  data_b;
    logic        valid_b, last_b, busy_b, done_b;

    always #5 clk = ~clk;

    project_info_streamer u_dut (
        .i_clk(clk), .i_rst(rst), .i_req(req),
        .i_major(major), .i_minor(minor), .i_patch(patch), .i_build(build),
        .i_commit_hash(hash),
        .o_data(data), .o_valid(valid), .i_ready(ready),
        .o_last(last), .o_busy(busy), .o_done(done)
    );

    project_info_streamer #(.DEPTH(16), .COMMIT_HASH_DEPTH(8)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_req(req_b),
        .i_major(major_b), .i_minor(minor_b), .i_patch(patch_b), .i_build(build_b),
        .i_commit_hash(hash_b),
        .o_data(data_b), .o_valid(valid_b), .i_ready(1'b1),
        .o_last(last_b), .o_busy(busy_b), .o_done(done_b)
    );

    typedef struct {
        logic [7:0]  major, minor, patch, build;
        logic [31:0] hash;
        int          mode;       // 0: ready=1, 1: ready 1,0,0,..., 2: random
        bit          hold_req;
        bit          corrupt;
        logic [7:0]  exp_csum;
    } vec_t;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic       got_last_q[$];
    logic [7:0] got_b_q[$];
    logic       got_b_last_q[$];
    int         done_cnt, done_b_cnt;
    bit         stall, pend_done;
    logic [7:0] held_data;
    logic       held_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Expected frame built straight from the field values: header, fields MSB first, XOR.
    task automatic model_frame(input logic [15:0] f0, input logic [15:0] f1,
                               input logic [15:0] f2, input logic [15:0] f3,
                               input logic [31:0] h, input int d, input int hd);
        logic [15:0] f[4];
        logic [7:0]  cs, b;
        f[0] = f0; f[1] = f1; f[2] = f2; f[3] = f3;
        cs = 8'h00;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int k = 0; k < 4; k++) begin
            for (int i = d / 8 - 1; i >= 0; i--) begin
                b = f[k][i*8 +: 8];
                exp_q.push_back(b);
                cs ^= b;
            end
        end
        for (int i = hd / 8 - 1; i >= 0; i--) begin
            b = h[i*8 +: 8];
            exp_q.push_back(b);
            cs ^= b;
        end
        exp_q.push_back(cs);
    endtask

    // Observe at negedge (inputs for the coming edge are stable), then drive after posedge.
    task automatic step();
        @(negedge clk);
        if (rst) begin
            stall = 0;
            pend_done = 0;
        end else begin
            if (stall) check("stall_hold", {valid, last, data}, {1'b1, held_last, held_data});
            if (pend_done) check("done_pulse", {63'd0, done}, 64'd1);
            else           check("no_spurious_done", {63'd0, done}, 64'd0);
            if (done) done_cnt++;
            pend_done = 0;
            if (valid && ready) begin
                got_q.push_back(data);
                got_last_q.push_back(last);
                pend_done = last;
            end
            stall     = valid && !ready;
            held_data = data;
            held_last = last;
            if (valid_b) begin
                got_b_q.push_back(data_b);
                got_b_last_q.push_back(last_b);
            end
            if (done_b) done_b_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic ready_for(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ((cyc - 1) % 3) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic compare_frame(input string tag, input logic [7:0] exp_csum);
        check({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({tag, "_byte"}, {56'd0, got_q[i]}, {56'd0, exp_q[i]});
            check({tag, "_last"}, {63'd0, got_last_q[i]}, 64'(i == exp_q.size() - 1));
        end
        if (got_q.size() > 0) check({tag, "_csum"}, {56'd0, got_q[got_q.size()-1]},
                                    {56'd0, exp_csum});
    endtask

    task automatic run_a(input string tag, input vec_t v);
        int cyc;
        model_frame({8'd0, v.major}, {8'd0, v.minor}, {8'd0, v.patch}, {8'd0, v.build},
                    v.hash, 8, 32);
        got_q.delete();
        got_last_q.delete();
        done_cnt = 0;
        major = v.major; minor = v.minor; patch = v.patch; build = v.build; hash = v.hash;
        req = 1'b1;
        ready = 1'b0;
        step();
        check({tag, "_hdr_latency"}, {55'd0, valid, data}, {55'd0, 1'b1, 8'hA5});
        check({tag, "_busy_start"}, {63'd0, busy}, 64'd1);
        if (v.corrupt) begin
            major = '1; minor = '1; patch = '1; build = '1; hash = '1;
        end
        cyc = 1;
        while (done_cnt == 0 && cyc < 300) begin
            ready = ready_for(v.mode, cyc);
            req   = v.hold_req && busy;
            step();
            if (got_q.size() < exp_q.size()) check({tag, "_busy"}, {63'd0, busy}, 64'd1);
            cyc++;
        end
        if (cyc >= 300) check({tag, "_timeout"}, 64'(done_cnt), 64'd1);
        req = 1'b0;
        compare_frame(tag, v.exp_csum);
        repeat (3) step();
        check({tag, "_single_done"}, 64'(done_cnt), 64'd1);
        check({tag, "_idle_after"}, {62'd0, valid, busy}, 64'd0);
    endtask

    vec_t tbl[6];
    vec_t rv;

    initial begin
        tbl[0] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'hDEADBEEF, 0, 1'b0, 1'b0, 8'h26};
        tbl[1] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'hDEADBEEF, 1, 1'b0, 1'b0, 8'h26};
        tbl[2] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'hDEADBEEF, 0, 1'b0, 1'b1, 8'h26};
        tbl[3] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'hDEADBEEF, 0, 1'b1, 1'b0, 8'h26};
        tbl[4] = '{8'h10, 8'h20, 8'h30, 8'h40, 32'h01020304, 0, 1'b0, 1'b0, 8'h44};
        tbl[5] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFFFFFF, 1, 1'b0, 1'b0, 8'h00};

        rst = 1'b1; req = 1'b0; ready = 1'b0;
        major = '0; minor = '0; patch = '0; build = '0; hash = '0;
        req_b = 1'b0; major_b = '0; minor_b = '0; patch_b = '0; build_b = '0; hash_b = '0;
        done_cnt = 0; done_b_cnt = 0; stall = 0; pend_done = 0;
        held_data = '0; held_last = 1'b0;
        repeat (3) step();
        check("reset_outputs", {52'd0, data, valid, last, busy, done}, 64'd0);
        check("reset_outputs_b", {52'd0, data_b, valid_b, last_b, busy_b, done_b}, 64'd0);
        rst = 1'b0;
        ready = 1'b1;
        repeat (2) step();
        check("idle_ready_no_xfer", 64'(got_q.size()), 64'd0);

        foreach (tbl[i]) run_a($sformatf("vec%0d", i), tbl[i]);

        // Reset while the payload byte AD is on the bus.
        model_frame(16'h01, 16'h02, 16'h03, 16'h04, 32'hDEADBEEF, 8, 32);
        got_q.delete(); got_last_q.delete(); done_cnt = 0;
        major = 8'h01; minor = 8'h02; patch = 8'h03; build = 8'h04; hash = 32'hDEADBEEF;
        req = 1'b1; ready = 1'b1;
        step();
        req = 1'b0;
        for (int i = 0; i < 20 && got_q.size() < 6; i++) step();
        check("rst_pre_byte", {55'd0, valid, data}, {55'd0, 1'b1, 8'hAD});
        rst = 1'b1;
        step();
        check("rst_abort", {52'd0, data, valid, last, busy, done}, 64'd0);
        rst = 1'b0;
        repeat (4) step();
        check("rst_no_done", 64'(done_cnt), 64'd0);
        run_a("after_rst", tbl[0]);

        for (int k = 0; k < 6; k++) begin
            rv.major = 8'($urandom); rv.minor = 8'($urandom);
            rv.patch = 8'($urandom); rv.build = 8'($urandom);
            rv.hash = $urandom; rv.mode = 2; rv.hold_req = 1'($urandom_range(0, 1));
            rv.corrupt = 1'($urandom_range(0, 1));
            rv.exp_csum = rv.major ^ rv.minor ^ rv.patch ^ rv.build ^
                          rv.hash[31:24] ^ rv.hash[23:16] ^ rv.hash[15:8] ^ rv.hash[7:0];
            run_a($sformatf("rand%0d", k), rv);
        end

        // 16-bit fields, 8-bit hash variant.
        model_frame(16'h0102, 16'h0, 16'h0, 16'h0, 32'h80, 16, 8);
        got_b_q.delete(); got_b_last_q.delete(); done_b_cnt = 0;
        major_b = 16'h0102; hash_b = 8'h80;
        req_b = 1'b1;
        step();
        req_b = 1'b0;
        for (int i = 0; i < 40 && done_b_cnt == 0; i++) step();
        check("b_done", 64'(done_b_cnt), 64'd1);
        check("b_len", 64'(got_b_q.size()), 64'd11);
        for (int i = 0; i < exp_q.size() && i < got_b_q.size(); i++) begin
            check("b_byte", {56'd0, got_b_q[i]}, {56'd0, exp_q[i]});
            check("b_last", {63'd0, got_b_last_q[i]}, 64'(i == exp_q.size() - 1));
        end
        if (got_b_q.size() == 11) check("b_csum", {56'd0, got_b_q[10]}, 64'h83);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
